// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read/write/scoreboard bundle between decode/writeback and regfile_sb
// master: pipeline side (drives addresses, write data, marks); slave: register file
// A1/A2 -> RD1/RD2, busy1/busy2 : read ports and their scoreboard bits
// A3/WD3/WE3                    : writeback port
// mark_en/mark_addr             : issue-time busy marking
// ready                         : clearing sweep finished
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   A1, A2, A3, mark_addr;
  logic [XLEN-1:0] RD1, RD2, WD3;
  logic            WE3, mark_en, busy1, busy2, ready;
  modport master (
    output A1, A2, A3, WD3, WE3, mark_en, mark_addr,
    input  RD1, RD2, busy1, busy2, ready
  );
  modport slave (
    input  A1, A2, A3, WD3, WE3, mark_en, mark_addr,
    output RD1, RD2, busy1, busy2, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with reset clearing sweep and busy scoreboard
// clk, rst : clock, asynchronous active-high reset
// bus      : regfile_sb_if.slave (read, write, mark and ready signals)
// REGFILE_BYPASS_EN defined: same-cycle write data and busy-clear forwarded to reads
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 2**AW;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef enum logic {INIT, RUN} state_t;
  state_t           state_q;
  logic [AW-1:0]    cnt_q;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic             ready, wr, mk, hit1, hit2;
  assign ready = state_q == RUN;
  assign wr    = ready & bus.WE3 & |bus.A3;
  assign mk    = ready & bus.mark_en & |bus.mark_addr;
  assign hit1  = BYP && wr && bus.A3 == bus.A1;
  assign hit2  = BYP && wr && bus.A3 == bus.A2;
  // a mark applied after the write clear lets a new producer supersede the old one
  always_comb begin
    busy_d = busy_q;
    if (wr) busy_d[bus.A3] = 1'b0;
    if (mk) busy_d[bus.mark_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) state_q <= RUN;
      end
    end
  end
  // storage has no reset; the INIT sweep zeroes it one entry per cycle
  always_ff @(posedge clk) begin
    if (state_q == INIT) regs_q[cnt_q] <= '0;
    else if (wr) regs_q[bus.A3] <= bus.WD3;
  end
  assign bus.ready = ready;
  assign bus.RD1   = (!ready || bus.A1 == '0) ? '0 : hit1 ? bus.WD3 : regs_q[bus.A1];
  assign bus.RD2   = (!ready || bus.A2 == '0) ? '0 : hit2 ? bus.WD3 : regs_q[bus.A2];
  assign bus.busy1 = ready & (hit1 ? (mk && bus.mark_addr == bus.A1) : busy_q[bus.A1]);
  assign bus.busy2 = ready & (hit2 ? (mk && bus.mark_addr == bus.A2) : busy_q[bus.A2]);
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: vector-table and scoreboard bench for regfile_sb
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif
  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        mk;
    logic [4:0]  ma, a1, a2;
    logic [31:0] rd1, rd2;
    logic        b1, b2;
  } vec_t;
  typedef struct {
    logic [31:0] rd1, rd2;
    logic        b1, b2;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[16];
  exp_t sb[$];
  regfile_sb_if #(.XLEN(32), .AW(5)) bus ();
  regfile_sb #(.XLEN(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                       input logic mk, input logic [4:0] ma, input logic [4:0] a1, input logic [4:0] a2);
    bus.WE3 = we; bus.A3 = a3; bus.WD3 = wd;
    bus.mark_en = mk; bus.mark_addr = ma; bus.A1 = a1; bus.A2 = a2;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    exp_t e;
    int   k;
    //            we    a3     wd             mk    ma     a1     a2     rd1                          rd2            b1           b2
    tbl[0]  = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd0, B ? 32'h12345678 : 32'h0, 32'h0,        1'b0,        1'b0};
    tbl[1]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd7, 5'd0, 32'h12345678,              32'h0,        1'b0,        1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 32'h0,                     32'h12345678, 1'b0,        1'b0};
    tbl[3]  = '{1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd9, 5'd7, B ? 32'hA5A5A5A5 : 32'h0, 32'h12345678, 1'b0,        1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'hA5A5A5A5,              32'h0,        1'b0,        1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd0, 32'h0,                     32'h0,        1'b0,        1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h0,                     32'h0,        1'b1,        1'b1};
    tbl[7]  = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 5'd3, 5'd0, B ? 32'h33 : 32'h0,        32'h0,        !B,          1'b0};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h33,                    32'h0,        1'b0,        1'b0};
    tbl[9]  = '{1'b1, 5'd3, 32'h44,       1'b1, 5'd3, 5'd3, 5'd0, B ? 32'h44 : 32'h33,       32'h0,        B,           1'b0};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h44,                    32'h0,        1'b1,        1'b0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd3, 32'h0,                     32'h44,       1'b0,        1'b1};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 32'h0,                     32'h44,       1'b0,        1'b1};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd0, 32'h0,                     32'h0,        1'b0,        1'b0};
    tbl[14] = '{1'b1, 5'd4, 32'hBEEF,     1'b1, 5'd4, 5'd4, 5'd0, B ? 32'hBEEF : 32'h0,      32'h0,        1'b1,        1'b0};
    tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd0, 32'hBEEF,                  32'h0,        1'b1,        1'b0};
    // reset values, with an INIT-time write held on the port
    drive(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 5'd5, 5'd5);
    #12;
    chk("rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("rst_rd1", bus.RD1, 32'h0);
    chk("rst_busy1", {31'h0, bus.busy1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // sweep: ready after exactly 32 rising edges; writes during INIT are dropped
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 32) bus.WE3 = 1'b0;
      #1;
      if (i >= 30) chk($sformatf("sweep_ready_%0d", i), {31'h0, bus.ready}, {31'h0, i == 32});
    end
    chk("init_write_dropped", bus.RD1, 32'h0);
    // table vectors through the scoreboard
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].mk, tbl[i].ma, tbl[i].a1, tbl[i].a2);
      sb.push_back('{tbl[i].rd1, tbl[i].rd2, tbl[i].b1, tbl[i].b2});
      #1;
      if (sb.size() == 0) chk("sb_empty", 32'h0, 32'h1);
      else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_rd1", i), bus.RD1, e.rd1);
        chk($sformatf("v%0d_rd2", i), bus.RD2, e.rd2);
        chk($sformatf("v%0d_busy1", i), {31'h0, bus.busy1}, {31'h0, e.b1});
        chk($sformatf("v%0d_busy2", i), {31'h0, bus.busy2}, {31'h0, e.b2});
        chk($sformatf("v%0d_ready", i), {31'h0, bus.ready}, 32'h1);
      end
    end
    // asynchronous reset between edges with x4 busy
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
    #1;
    chk("pre_rst_busy1", {31'h0, bus.busy1}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("mid_rst_busy1", {31'h0, bus.busy1}, 32'h0);
    chk("mid_rst_rd1", bus.RD1, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (!bus.ready && k < 40) begin
      @(negedge clk);
      k++;
      #1;
    end
    chk("resweep_edges", k, 32);
    chk("resweep_x4", bus.RD1, 32'h0);
    chk("resweep_busy1", {31'h0, bus.busy1}, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
